// File: rtl/meas_sw_debounce.sv
// meas_sw_debounce: sync+debounce switch bus (clk, reset_i, sw_raw_i -> sw_o, rise_o, fall_o, chg_valid_o/chg_mask_o/chg_ack_i, ovf_o, glitch_cnt_o; glitch counter only with MEAS_SW_GLITCH_CNT_EN)
module meas_sw_debounce #(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES = 100000,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] sw_raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             chg_valid_o,
  output logic [WIDTH-1:0] chg_mask_o,
  input  logic             chg_ack_i,
  output logic             ovf_o,
  output logic [15:0]      glitch_cnt_o
);
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] s, diff, hit, acc;
  assign s = sync_q[SYNC_STAGES-1];
  assign diff = s ^ sw_o;
  assign acc = rise_o | fall_o;
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) hit[i] = diff[i] && cnt[i] == CNT_MAX;
  end
  always_ff @(posedge clk or posedge reset_i)
    if (reset_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      sw_o <= RESET_VAL;
      rise_o <= '0;
      fall_o <= '0;
    end else begin
      sync_q[0] <= sw_raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < WIDTH; i++) cnt[i] <= (!diff[i] || hit[i]) ? '0 : cnt[i] + 1'b1;
      sw_o <= sw_o ^ hit;
      rise_o <= hit & s;
      fall_o <= hit & ~s;
    end
  always_ff @(posedge clk or posedge reset_i)
    if (reset_i) begin
      chg_valid_o <= 1'b0;
      chg_mask_o <= '0;
      ovf_o <= 1'b0;
    end else if (!chg_valid_o) begin
      if (|acc) begin
        chg_valid_o <= 1'b1;
        chg_mask_o <= acc;
      end
    end else if (!chg_ack_i) begin
      chg_mask_o <= chg_mask_o | acc;
      ovf_o <= ovf_o | (|(chg_mask_o & acc));
    end else begin
      chg_valid_o <= |acc;
      chg_mask_o <= acc;
      ovf_o <= 1'b0;
    end
`ifdef MEAS_SW_GLITCH_CNT_EN
  logic [31:0] sum;
  always_comb begin
    sum = {16'b0, glitch_cnt_o};
    for (int i = 0; i < WIDTH; i++) sum = sum + 32'(!diff[i] && cnt[i] != '0);
  end
  always_ff @(posedge clk or posedge reset_i)
    if (reset_i) glitch_cnt_o <= '0;
    else glitch_cnt_o <= sum > 32'hFFFF ? 16'hFFFF : sum[15:0];
`else
  assign glitch_cnt_o = '0;
`endif
endmodule
